// File: rtl/bsw_pkg.sv
// Shared definitions for the BSW tile driver: FSM encoding and result word layout.
package bsw_pkg;

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_LOAD_REF   = 3'd1,
      S_LOAD_QUERY = 3'd2,
      S_PARAM      = 3'd3,
      S_START      = 3'd4,
      S_WAIT       = 3'd5,
      S_CAPTURE    = 3'd6,
      S_OUTPUT     = 3'd7
   } bsw_state_e;

   localparam int RESULT_WIDTH      = 512;
   localparam int RES_FIELD_WIDTH   = 32;
   localparam int RES_TILE_ID_LSB   = 0;
   localparam int RES_ARRAY_ID_LSB  = 32;
   localparam int RES_SCORE_LSB     = 64;
   localparam int RES_REF_POS_LSB   = 96;
   localparam int RES_QUERY_POS_LSB = 128;

endpackage

// File: rtl/bsw_tile_driver_if.sv
// Host, sequence, result and systolic-array signals of the tile driver, plus status/debug.
interface bsw_tile_driver_if #(
   parameter int PE_WIDTH          = 25,
   parameter int BLOCK_WIDTH       = 3,
   parameter int LOG_MAX_TILE_SIZE = 11
);
   import bsw_pkg::*;

   localparam int L  = LOG_MAX_TILE_SIZE;
   localparam int AW = LOG_MAX_TILE_SIZE - BLOCK_WIDTH;
   localparam int DW = 8 << BLOCK_WIDTH;
   localparam int PW = 13 * PE_WIDTH;

   // Every *_valid/*_ready pair transfers exactly on a rising clk edge where both are high;
   // a source holds valid and its payload stable until that edge.
   logic                    cmd_valid;
   logic                    cmd_ready;
   logic [L-1:0]            cmd_ref_len;
   logic [L-1:0]            cmd_query_len;
   logic [7:0]              cmd_align_fields;
   logic                    cmd_set_param;
   logic [PW-1:0]           cmd_params;

   logic                    seq_valid;
   logic                    seq_ready;
   logic [DW-1:0]           seq_data;

   logic                    res_valid;
   logic                    res_ready;
   logic [RESULT_WIDTH-1:0] res_data;

   logic                    arr_ready;
   logic                    arr_done;
   logic [RESULT_WIDTH-1:0] arr_tile_output;
   logic                    arr_start;
   logic                    arr_set_param;
   logic                    arr_clear_done;
   logic                    arr_ref_wr_en;
   logic                    arr_query_wr_en;
   logic [AW-1:0]           arr_ref_addr;
   logic [AW-1:0]           arr_query_addr;
   logic [DW-1:0]           arr_ref_in;
   logic [DW-1:0]           arr_query_in;
   logic [L-1:0]            arr_ref_len;
   logic [L-1:0]            arr_query_len;
   logic [7:0]              arr_align_fields;
   logic [PW-1:0]           arr_in_params;

   logic                    busy;
   logic [31:0]             tiles_done;
   bsw_state_e              dbg_state;

   modport master (
      input  cmd_valid, cmd_ref_len, cmd_query_len, cmd_align_fields, cmd_set_param, cmd_params,
      output cmd_ready,
      input  seq_valid, seq_data,
      output seq_ready,
      input  res_ready,
      output res_valid, res_data,
      input  arr_ready, arr_done, arr_tile_output,
      output arr_start, arr_set_param, arr_clear_done, arr_ref_wr_en, arr_query_wr_en,
      output arr_ref_addr, arr_query_addr, arr_ref_in, arr_query_in,
      output arr_ref_len, arr_query_len, arr_align_fields, arr_in_params,
      output busy, tiles_done, dbg_state
   );

   modport slave (
      output cmd_valid, cmd_ref_len, cmd_query_len, cmd_align_fields, cmd_set_param, cmd_params,
      input  cmd_ready,
      output seq_valid, seq_data,
      input  seq_ready,
      output res_ready,
      input  res_valid, res_data,
      output arr_ready, arr_done, arr_tile_output,
      input  arr_start, arr_set_param, arr_clear_done, arr_ref_wr_en, arr_query_wr_en,
      input  arr_ref_addr, arr_query_addr, arr_ref_in, arr_query_in,
      input  arr_ref_len, arr_query_len, arr_align_fields, arr_in_params,
      input  busy, tiles_done, dbg_state
   );

endinterface

// File: rtl/bsw_seq_writer.sv
// Streams sequence words into array memory: counts remaining words, issues a registered
// write strobe with a 1-based wrapping word address one cycle after each accepted beat.
module bsw_seq_writer #(
   parameter int L  = 11,
   parameter int BW = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_load,
   input  logic [L:0]          i_words,
   input  logic                i_active,
   input  logic                i_is_ref,
   input  logic                i_seq_valid,
   input  logic [(8<<BW)-1:0]  i_seq_data,
   output logic                o_seq_ready,
   output logic                o_last,
   output logic                o_ref_wr_en,
   output logic                o_query_wr_en,
   output logic [L-BW-1:0]     o_addr,
   output logic [(8<<BW)-1:0]  o_data
);

   logic [L:0]      r_remaining;
   logic [L-BW-1:0] r_addr;
   logic            w_accept;

   assign o_seq_ready = i_active && (r_remaining != '0);
   assign w_accept    = o_seq_ready && i_seq_valid;
   assign o_last      = w_accept && (r_remaining == (L+1)'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_remaining   <= '0;
         r_addr        <= '0;
         o_ref_wr_en   <= 1'b0;
         o_query_wr_en <= 1'b0;
         o_addr        <= '0;
         o_data        <= '0;
      end else begin
         // A load may coincide with the final beat of the previous sequence; the load wins.
         if (i_load) begin
            r_remaining <= i_words;
            r_addr      <= '0;
         end else if (w_accept) begin
            r_remaining <= r_remaining - (L+1)'(1);
            r_addr      <= r_addr + 1'b1;
         end
         o_ref_wr_en   <= w_accept && i_is_ref;
         o_query_wr_en <= w_accept && !i_is_ref;
         if (w_accept) begin
            o_addr <= r_addr + 1'b1;
            o_data <= i_seq_data;
         end
      end
   end

endmodule

// File: rtl/bsw_tile_driver.sv
// Sequences one alignment tile through the systolic array: load ref/query, optional
// parameter load, start, wait for done, capture the result and hand it to the host.
module bsw_tile_driver
   import bsw_pkg::*;
#(
   parameter int PE_WIDTH          = 25,
   parameter int BLOCK_WIDTH       = 3,
   parameter int LOG_MAX_TILE_SIZE = 11
) (
   input logic              clk,
   input logic              rst_n,
   bsw_tile_driver_if.master drv_if
);

   localparam int L  = LOG_MAX_TILE_SIZE;
   localparam int AW = LOG_MAX_TILE_SIZE - BLOCK_WIDTH;
   localparam int DW = 8 << BLOCK_WIDTH;
   localparam int PW = 13 * PE_WIDTH;

   bsw_state_e              r_state;
   bsw_state_e              w_next;
   logic                    r_cmd_ready;
   logic [L-1:0]            r_ref_len;
   logic [L-1:0]            r_query_len;
   logic [7:0]              r_align;
   logic [PW-1:0]           r_params;
   logic                    r_set_param;
   logic                    r_arr_start;
   logic                    r_arr_set_param;
   logic                    r_arr_clear_done;
   logic [RESULT_WIDTH-1:0] r_res_data;
   logic [31:0]             r_tiles_done;

   logic                    w_cmd_fire;
   logic [L:0]              w_cmd_ref_words;
   logic [L:0]              w_cmd_query_words;
   logic [L:0]              w_query_words;
   logic                    w_load;
   logic [L:0]              w_load_words;
   logic                    w_last;
   logic                    w_wr_ref;
   logic                    w_wr_query;
   logic [AW-1:0]           w_wr_addr;
   logic [DW-1:0]           w_wr_data;
   bsw_state_e              w_after_load;

   // Word count is evaluated one bit wider than the length so a full-size tile cannot overflow.
   function automatic logic [L:0] words_of(input logic [L-1:0] len);
      return ({1'b0, len} + (L+1)'((1 << BLOCK_WIDTH) - 1)) >> BLOCK_WIDTH;
   endfunction

   assign w_cmd_fire        = drv_if.cmd_valid && r_cmd_ready;
   assign w_cmd_ref_words   = words_of(drv_if.cmd_ref_len);
   assign w_cmd_query_words = words_of(drv_if.cmd_query_len);
   assign w_query_words     = words_of(r_query_len);
   assign w_after_load      = r_set_param ? S_PARAM : S_START;

   assign w_load       = w_cmd_fire || ((r_state == S_LOAD_REF) && w_last);
   assign w_load_words = w_cmd_fire ? ((w_cmd_ref_words != '0) ? w_cmd_ref_words : w_cmd_query_words)
                                    : w_query_words;

   bsw_seq_writer #(.L(L), .BW(BLOCK_WIDTH)) u_writer (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_load       (w_load),
      .i_words      (w_load_words),
      .i_active     ((r_state == S_LOAD_REF) || (r_state == S_LOAD_QUERY)),
      .i_is_ref     (r_state == S_LOAD_REF),
      .i_seq_valid  (drv_if.seq_valid),
      .i_seq_data   (drv_if.seq_data),
      .o_seq_ready  (drv_if.seq_ready),
      .o_last       (w_last),
      .o_ref_wr_en  (w_wr_ref),
      .o_query_wr_en(w_wr_query),
      .o_addr       (w_wr_addr),
      .o_data       (w_wr_data)
   );

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_cmd_fire) begin
               if (w_cmd_ref_words != '0)        w_next = S_LOAD_REF;
               else if (w_cmd_query_words != '0) w_next = S_LOAD_QUERY;
               else if (drv_if.cmd_set_param)    w_next = S_PARAM;
               else                              w_next = S_START;
            end
         end
         S_LOAD_REF:   if (w_last) w_next = (w_query_words != '0) ? S_LOAD_QUERY : w_after_load;
         S_LOAD_QUERY: if (w_last) w_next = w_after_load;
         S_PARAM:      w_next = S_START;
         S_START:      if (drv_if.arr_ready) w_next = S_WAIT;
         S_WAIT:       if (drv_if.arr_done) w_next = S_CAPTURE;
         S_CAPTURE:    w_next = S_OUTPUT;
         S_OUTPUT:     if (drv_if.res_ready) w_next = S_IDLE;
         default:      w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state          <= S_IDLE;
         r_cmd_ready      <= 1'b0;
         r_ref_len        <= '0;
         r_query_len      <= '0;
         r_align          <= '0;
         r_params         <= '0;
         r_set_param      <= 1'b0;
         r_arr_start      <= 1'b0;
         r_arr_set_param  <= 1'b0;
         r_arr_clear_done <= 1'b0;
         r_res_data       <= '0;
         r_tiles_done     <= '0;
      end else begin
         r_state          <= w_next;
         r_cmd_ready      <= (w_next == S_IDLE);
         r_arr_set_param  <= (w_next == S_PARAM);
         r_arr_start      <= (r_state == S_START) && drv_if.arr_ready;
         r_arr_clear_done <= (r_state == S_WAIT) && drv_if.arr_done;
         if (w_cmd_fire) begin
            r_ref_len   <= drv_if.cmd_ref_len;
            r_query_len <= drv_if.cmd_query_len;
            r_align     <= drv_if.cmd_align_fields;
            r_params    <= drv_if.cmd_params;
            r_set_param <= drv_if.cmd_set_param;
         end
         // The array refreshes its tile output on the cycle it raises done, so sample one later.
         if (r_state == S_CAPTURE) begin
            r_res_data   <= drv_if.arr_tile_output;
            r_tiles_done <= r_tiles_done + 32'd1;
         end
      end
   end

   assign drv_if.cmd_ready        = r_cmd_ready;
   assign drv_if.res_valid        = (r_state == S_OUTPUT);
   assign drv_if.res_data         = r_res_data;
   assign drv_if.arr_start        = r_arr_start;
   assign drv_if.arr_set_param    = r_arr_set_param;
   assign drv_if.arr_clear_done   = r_arr_clear_done;
   assign drv_if.arr_ref_wr_en    = w_wr_ref;
   assign drv_if.arr_query_wr_en  = w_wr_query;
   assign drv_if.arr_ref_addr     = w_wr_addr;
   assign drv_if.arr_query_addr   = w_wr_addr;
   assign drv_if.arr_ref_in       = w_wr_data;
   assign drv_if.arr_query_in     = w_wr_data;
   assign drv_if.arr_ref_len      = r_ref_len;
   assign drv_if.arr_query_len    = r_query_len;
   assign drv_if.arr_align_fields = r_align;
   assign drv_if.arr_in_params    = r_params;
   assign drv_if.busy             = (r_state != S_IDLE);
   assign drv_if.tiles_done       = r_tiles_done;
   assign drv_if.dbg_state        = r_state;

endmodule

// File: tb/tb_bsw_tile_driver.sv
// Directed scoreboard bench for bsw_tile_driver: expected writes/results are queued at
// stimulus time and a negedge monitor pops and compares them as the DUT produces them.
module tb_bsw_tile_driver;
   import bsw_pkg::*;

   localparam int PE_WIDTH = 25;
   localparam int BW       = 3;
   localparam int L        = 11;
   localparam int AW       = L - BW;
   localparam int DW       = 8 << BW;
   localparam int PW       = 13 * PE_WIDTH;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;
   int   n_start;
   int   n_setp;
   int   n_clear;
   int   exp_tiles;

   logic [AW+DW-1:0]        exp_ref_q[$];
   logic [AW+DW-1:0]        exp_query_q[$];
   logic [RESULT_WIDTH-1:0] exp_res_q[$];

   bsw_tile_driver_if #(.PE_WIDTH(PE_WIDTH), .BLOCK_WIDTH(BW), .LOG_MAX_TILE_SIZE(L)) dif ();

   bsw_tile_driver #(.PE_WIDTH(PE_WIDTH), .BLOCK_WIDTH(BW), .LOG_MAX_TILE_SIZE(L)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .drv_if(dif)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic report_fail(input string name, input string what);
      n_checks++;
      n_fail++;
      $display("FAIL %s: %s", name, what);
   endtask

   function automatic logic [DW-1:0] ref_word(input int i);
      return {32'h0F0F_A5A5, 32'(i)};
   endfunction

   function automatic logic [DW-1:0] query_word(input int i);
      return {32'hC3C3_5A5A, 32'(i)};
   endfunction

   function automatic logic [RESULT_WIDTH-1:0] make_tile(input logic [31:0] score, input int id);
      logic [RESULT_WIDTH-1:0] t;
      t = '0;
      t[RES_TILE_ID_LSB +: 32]   = 32'(id);
      t[RES_ARRAY_ID_LSB +: 32]  = 32'h0000_0003;
      t[RES_SCORE_LSB +: 32]     = score;
      t[RES_REF_POS_LSB +: 32]   = 32'h0000_0100 + 32'(id);
      t[RES_QUERY_POS_LSB +: 32] = 32'h0000_0200 + 32'(id);
      return t;
   endfunction

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      logic [AW+DW-1:0]        e;
      logic [RESULT_WIDTH-1:0] r;
      if (!rst_n) begin
         check("strobes_in_reset", 64'({dif.arr_start, dif.arr_set_param, dif.arr_clear_done,
                                        dif.arr_ref_wr_en, dif.arr_query_wr_en}), 64'd0);
      end else begin
         if (dif.arr_ref_wr_en && dif.arr_query_wr_en)
            report_fail("wr_overlap", "ref and query write enables both high, expected at most one");
         if (dif.arr_ref_wr_en) begin
            if (exp_ref_q.size() == 0) report_fail("ref_extra_write", "ref write seen, expected none");
            else begin
               e = exp_ref_q.pop_front();
               check("ref_addr", 64'(dif.arr_ref_addr), 64'(e[DW +: AW]));
               check("ref_data", 64'(dif.arr_ref_in), 64'(e[DW-1:0]));
            end
         end
         if (dif.arr_query_wr_en) begin
            if (exp_query_q.size() == 0) report_fail("query_extra_write", "query write seen, expected none");
            else begin
               e = exp_query_q.pop_front();
               check("query_addr", 64'(dif.arr_query_addr), 64'(e[DW +: AW]));
               check("query_data", 64'(dif.arr_query_in), 64'(e[DW-1:0]));
            end
         end
         if (dif.arr_start)      n_start++;
         if (dif.arr_set_param)  n_setp++;
         if (dif.arr_clear_done) n_clear++;
         if (dif.res_valid && dif.res_ready) begin
            if (exp_res_q.size() == 0) report_fail("res_extra", "result handshake seen, expected none");
            else begin
               r = exp_res_q.pop_front();
               check("res_score", 64'(dif.res_data[RES_SCORE_LSB +: 32]), 64'(r[RES_SCORE_LSB +: 32]));
               check("res_data_full", 64'(dif.res_data == r), 64'd1);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send_cmd(input int rl, input int ql, input bit sp);
      bit hs;
      int t;
      dif.cmd_valid        = 1'b1;
      dif.cmd_ref_len      = L'(rl);
      dif.cmd_query_len    = L'(ql);
      dif.cmd_align_fields = 8'h5A;
      dif.cmd_set_param    = sp;
      dif.cmd_params       = '0;
      dif.cmd_params[24:0] = 25'h1ABCDE ^ 25'(rl);
      t = 0;
      do begin
         @(negedge clk); hs = dif.cmd_ready;
         @(posedge clk); #1; t++;
      end while (!hs && t < 200);
      dif.cmd_valid = 1'b0;
      if (!hs) report_fail("cmd_timeout", "cmd_ready never asserted within 200 cycles");
   endtask

   task automatic send_words(input int n, input bit is_ref);
      bit hs;
      int t;
      for (int i = 0; i < n; i++) begin
         dif.seq_valid = 1'b1;
         dif.seq_data  = is_ref ? ref_word(i) : query_word(i);
         t = 0;
         do begin
            @(negedge clk); hs = dif.seq_ready;
            @(posedge clk); #1; t++;
         end while (!hs && t < 50);
         if (!hs) begin
            report_fail("seq_timeout", "seq_ready never asserted within 50 cycles");
            break;
         end
      end
      dif.seq_valid = 1'b0;
   endtask

   task automatic run_tile(input int rl, input int ql, input bit sp, input int rdy_delay,
                           input logic [31:0] score, input int hold, input bit rst_in_wait);
      int s0, p0, c0, t;
      int nr, nq;
      logic [RESULT_WIDTH-1:0] tout;
      s0 = n_start; p0 = n_setp; c0 = n_clear;
      nr = (rl + 7) / 8;
      nq = (ql + 7) / 8;
      dif.arr_ready = (rdy_delay == 0);
      for (int i = 0; i < nr; i++) exp_ref_q.push_back({AW'(i + 1), ref_word(i)});
      for (int i = 0; i < nq; i++) exp_query_q.push_back({AW'(i + 1), query_word(i)});

      send_cmd(rl, ql, sp);
      check("arr_ref_len", 64'(dif.arr_ref_len), 64'(rl));
      check("arr_query_len", 64'(dif.arr_query_len), 64'(ql));
      check("arr_align", 64'(dif.arr_align_fields), 64'h5A);
      check("arr_params", 64'(dif.arr_in_params[24:0]), 64'(25'h1ABCDE ^ 25'(rl)));
      send_words(nr, 1'b1);
      send_words(nq, 1'b0);

      for (int i = 0; i < rdy_delay; i++) begin
         @(negedge clk);
         check("start_before_ready", 64'(n_start - s0), 64'd0);
      end
      if (rdy_delay > 0) begin
         @(posedge clk); #1;
         dif.arr_ready = 1'b1;
      end

      t = 0;
      while (n_start == s0 && t < 100) begin @(negedge clk); t++; end
      if (n_start == s0) report_fail("start_timeout", "arr_start not seen within 100 cycles");
      check("queues_drained", 64'(exp_ref_q.size() + exp_query_q.size()), 64'd0);
      check("set_param_pulses", 64'(n_setp - p0), 64'(sp));

      if (rst_in_wait) begin
         repeat (3) @(negedge clk);
         check("in_wait", 64'(dif.dbg_state), 64'(S_WAIT));
         @(posedge clk); #1;
         rst_n = 1'b0;
         exp_tiles = 0;
         repeat (3) @(negedge clk);
         check("rst_busy", 64'(dif.busy), 64'd0);
         check("rst_res_valid", 64'(dif.res_valid), 64'd0);
         @(posedge clk); #1;
         rst_n = 1'b1;
         repeat (3) @(negedge clk);
         check("rst_no_clear", 64'(n_clear - c0), 64'd0);
         check("rst_tiles_done", 64'(dif.tiles_done), 64'd0);
         check("rst_start_once", 64'(n_start - s0), 64'd1);
         @(posedge clk); #1;
         return;
      end

      repeat (2) @(posedge clk);
      #1;
      dif.arr_done        = 1'b1;
      dif.arr_tile_output = make_tile(32'hDEAD, 99);
      @(posedge clk); #1;
      tout = make_tile(score, exp_tiles + 1);
      dif.arr_tile_output = tout;
      exp_res_q.push_back(tout);

      t = 0;
      while (!dif.res_valid && t < 20) begin @(negedge clk); t++; end
      if (!dif.res_valid) report_fail("res_timeout", "res_valid not seen within 20 cycles");
      @(posedge clk); #1;
      dif.arr_done        = 1'b0;
      dif.arr_tile_output = make_tile(32'hBAD0, 77);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_score", 64'(dif.res_data[RES_SCORE_LSB +: 32]), 64'(score));
         check("hold_cmd_ready", 64'({dif.cmd_ready, dif.seq_ready}), 64'd0);
         check("hold_busy_valid", 64'({dif.busy, dif.res_valid}), 64'h3);
      end

      if (hold > 0) begin @(posedge clk); #1; end
      dif.res_ready = 1'b1;
      @(negedge clk);
      check("hs_valid", 64'(dif.res_valid), 64'd1);
      check("hs_cmd_ready_low", 64'(dif.cmd_ready), 64'd0);
      @(posedge clk); #1;
      dif.res_ready = 1'b0;
      exp_tiles++;
      @(negedge clk);
      check("cmd_ready_after_hs", 64'(dif.cmd_ready), 64'd1);
      check("busy_after_hs", 64'(dif.busy), 64'd0);
      check("start_pulses", 64'(n_start - s0), 64'd1);
      check("clear_pulses", 64'(n_clear - c0), 64'd1);
      check("tiles_done", 64'(dif.tiles_done), 64'(exp_tiles));
      @(posedge clk); #1;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      n_checks = 0; n_fail = 0; n_start = 0; n_setp = 0; n_clear = 0; exp_tiles = 0;
      rst_n                = 1'b0;
      dif.cmd_valid        = 1'b0;
      dif.cmd_ref_len      = '0;
      dif.cmd_query_len    = '0;
      dif.cmd_align_fields = '0;
      dif.cmd_set_param    = 1'b0;
      dif.cmd_params       = '0;
      dif.seq_valid        = 1'b0;
      dif.seq_data         = '0;
      dif.res_ready        = 1'b0;
      dif.arr_ready        = 1'b0;
      dif.arr_done         = 1'b0;
      dif.arr_tile_output  = '0;

      repeat (2) @(negedge clk);
      check("reset_cmd_ready", 64'(dif.cmd_ready), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("reset_cmd_ready_release", 64'(dif.cmd_ready), 64'd1);
      check("reset_flags", 64'({dif.busy, dif.seq_ready, dif.res_valid, dif.arr_start}), 64'd0);
      check("reset_tiles_done", 64'(dif.tiles_done), 64'd0);
      check("reset_res_data", 64'(dif.res_data == '0), 64'd1);
      check("reset_arr_len", 64'({dif.arr_ref_len, dif.arr_query_len}), 64'd0);
      @(posedge clk); #1;

      run_tile(16,   9,  1'b1, 0,  32'h0000_01F4, 50, 1'b0);
      run_tile(2047, 0,  1'b0, 20, 32'h0000_0055, 0,  1'b0);
      run_tile(8,    8,  1'b0, 0,  32'h0000_0077, 0,  1'b1);
      run_tile(0,    17, 1'b1, 0,  32'h0000_0ABC, 3,  1'b0);

      repeat (3) @(negedge clk);
      check("final_queues", 64'(exp_ref_q.size() + exp_query_q.size() + exp_res_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
